// File: rtl/overlay_pkg.sv
// ============================================================================
// Module   : overlay_pkg
// Purpose  : Shared word layout, FSM state encoding and source-pick helper
//            for the overlay sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package overlay_pkg;

    localparam int WORD_W    = 54;
    localparam int MASK_OFF  = 50;
    localparam int MASK_W    = 4;
    localparam int FRAME_OFF = 49;
    localparam int FRAME_W   = 1;
    localparam int ADDR_OFF  = 32;
    localparam int ADDR_W    = 17;
    localparam int PIXEL_OFF = 0;
    localparam int PIXEL_W   = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        STREAM = 3'd2,
        DACK   = 3'd3,
        NEXT   = 3'd4
    } state_e;

    // Returns {found, index} of the lowest set bit of en at or above from.
    function automatic logic [3:0] first_src(input logic [7:0] en, input logic [3:0] from);
        logic [3:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (en[i] && (4'(i) >= from)) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/overlay_word_mux.sv
// ============================================================================
// Module   : overlay_word_mux
// Purpose  : Combinational source-to-frame-buffer word path with frame-bit
//            substitution and ready demux.
// Revision : 1.0
// ============================================================================
`default_nettype none

module overlay_word_mux
    import overlay_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 1
) (
    input  logic [SEL_W-1:0]          sel_i,
    input  logic                      active_i,
    input  logic                      frame_i,
    input  logic [WORD_W*NUM_SRC-1:0] src_dout_i,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    input  logic                      fb_ready_i,
    output logic [WORD_W-1:0]         fb_dout_o,
    output logic                      fb_valid_o,
    output logic [NUM_SRC-1:0]        src_ready_o
);

    always_comb begin
        fb_dout_o   = '0;
        fb_valid_o  = 1'b0;
        src_ready_o = '0;
        if (active_i) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (SEL_W'(i) == sel_i) begin
                    fb_dout_o            = src_dout_i[i*WORD_W +: WORD_W];
                    fb_dout_o[FRAME_OFF] = frame_i;
                    fb_valid_o           = src_valid_i[i];
                    src_ready_o[i]       = fb_ready_i;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/overlay_sched.sv
// ============================================================================
// Module   : overlay_sched
// Purpose  : Per-frame overlay source sequencer and frame-buffer write arbiter.
//            Optional start_ack watchdog enabled by OVERLAY_SCHED_WDOG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module overlay_sched
    import overlay_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int WDOG_CYC = 1024
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      trigger,
    input  logic [NUM_SRC-1:0]        src_en,
    output logic [NUM_SRC-1:0]        src_start,
    input  logic [NUM_SRC-1:0]        src_start_ack,
    input  logic [NUM_SRC-1:0]        src_done,
    output logic [NUM_SRC-1:0]        src_done_ack,
    input  logic [WORD_W*NUM_SRC-1:0] src_dout,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [WORD_W-1:0]         fb_dout,
    output logic                      fb_valid,
    input  logic                      fb_ready,
    output logic                      busy,
    output logic                      pass_done,
    output logic                      overrun,
    output logic [NUM_SRC-1:0]        skip_err
);

    localparam int K_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int WD_W = $clog2(WDOG_CYC + 1);
`ifdef OVERLAY_SCHED_WDOG_EN
    localparam logic WDOG_ON = 1'b1;
`else
    localparam logic WDOG_ON = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [NUM_SRC-1:0] en_q, en_d;
    logic               frame_q, frame_d;
    logic               pending_q, pending_d;
    logic [NUM_SRC-1:0] skip_q, skip_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [7:0]         en8;
    logic [3:0]         pick;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            en_q      <= '0;
            frame_q   <= 1'b1;
            pending_q <= 1'b0;
            skip_q    <= '0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            en_q      <= en_d;
            frame_q   <= frame_d;
            pending_q <= pending_d;
            skip_q    <= skip_d;
            wdog_q    <= wdog_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        en_d         = en_q;
        frame_d      = frame_q;
        pending_d    = pending_q;
        skip_d       = skip_q;
        wdog_d       = '0;
        src_start    = '0;
        src_done_ack = '0;
        pass_done    = 1'b0;
        overrun      = 1'b0;
        en8          = '0;
        pick         = '0;

        // Triggers arriving mid-pass queue one deep; any further ones are dropped.
        if (trigger && (state_q != IDLE)) begin
            if (pending_q) overrun   = 1'b1;
            else           pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trigger || pending_q) begin
                    pending_d            = 1'b0;
                    en_d                 = src_en;
                    skip_d               = '0;
                    en8[NUM_SRC-1:0]     = src_en;
                    pick                 = first_src(en8, 4'd0);
                    if (pick[3]) begin
                        k_d     = K_W'(pick[2:0]);
                        state_d = START;
                    end else begin
                        frame_d   = ~frame_q;
                        pass_done = 1'b1;
                    end
                end
            end
            START: begin
                src_start[k_q] = 1'b1;
                wdog_d         = wdog_q + 1'b1;
                if (src_start_ack[k_q]) begin
                    state_d = STREAM;
                end else if (WDOG_ON && (wdog_q == WD_W'(WDOG_CYC - 1))) begin
                    skip_d[k_q] = 1'b1;
                    state_d     = NEXT;
                end
            end
            STREAM: begin
                if (src_done[k_q]) state_d = DACK;
            end
            DACK: begin
                src_done_ack[k_q] = 1'b1;
                if (!src_done[k_q]) state_d = NEXT;
            end
            NEXT: begin
                en8[NUM_SRC-1:0] = en_q;
                pick             = first_src(en8, 4'(k_q) + 4'd1);
                if (pick[3]) begin
                    k_d     = K_W'(pick[2:0]);
                    state_d = START;
                end else begin
                    frame_d   = ~frame_q;
                    pass_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign skip_err = skip_q;

    overlay_word_mux #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (K_W)
    ) u_word_mux (
        .sel_i       (k_q),
        .active_i    (state_q == STREAM),
        .frame_i     (frame_q),
        .src_dout_i  (src_dout),
        .src_valid_i (src_valid),
        .fb_ready_i  (fb_ready),
        .fb_dout_o   (fb_dout),
        .fb_valid_o  (fb_valid),
        .src_ready_o (src_ready)
    );

endmodule

`default_nettype wire

// File: tb/tb_overlay_sched.sv
// ============================================================================
// Module   : tb_overlay_sched
// Purpose  : Self-checking bench for overlay_sched with behavioural sources
//            and an expected-word scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_overlay_sched;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         trigger;
    logic [1:0]   src_en;
    logic [1:0]   src_start;
    logic [1:0]   src_start_ack;
    logic [1:0]   src_done;
    logic [1:0]   src_done_ack;
    logic [107:0] src_dout;
    logic [1:0]   src_valid;
    logic [1:0]   src_ready;
    logic [53:0]  fb_dout;
    logic         fb_valid;
    logic         fb_ready;
    logic         busy;
    logic         pass_done;
    logic         overrun;
    logic [1:0]   skip_err;

    always #5 clock = ~clock;

    overlay_sched #(
        .NUM_SRC  (2),
        .WDOG_CYC (16)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .trigger       (trigger),
        .src_en        (src_en),
        .src_start     (src_start),
        .src_start_ack (src_start_ack),
        .src_done      (src_done),
        .src_done_ack  (src_done_ack),
        .src_dout      (src_dout),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .fb_dout       (fb_dout),
        .fb_valid      (fb_valid),
        .fb_ready      (fb_ready),
        .busy          (busy),
        .pass_done     (pass_done),
        .overrun       (overrun),
        .skip_err      (skip_err)
    );

    int          total = 0;
    int          bad   = 0;
    logic [53:0] exp_q[$];
    int          nwords[2];
    int          st[2];
    int          widx[2];
    logic        xfer[2];
    bit          noack[2];
    int          pd_cnt, ov_cnt, words_seen;
    bit          start0_seen;
    bit          tog;
    logic        rdy_cfg;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [53:0] mk(input int s, input int w);
        return {4'(w + s), 1'(w), 17'(s * 256 + w), 8'(s), 8'hA5, 16'(w)};
    endfunction

    task automatic push_pass(input logic [1:0] en, input logic fr);
        logic [53:0] word;
        for (int s = 0; s < 2; s++) begin
            if (en[s]) begin
                for (int w = 0; w < nwords[s]; w++) begin
                    word     = mk(s, w);
                    word[49] = fr;
                    exp_q.push_back(word);
                end
            end
        end
    endtask

    task automatic clear_counts();
        pd_cnt      = 0;
        ov_cnt      = 0;
        words_seen  = 0;
        start0_seen = 0;
    endtask

    task automatic do_trigger();
        @(negedge clock);
        trigger = 1'b1;
        @(negedge clock);
        trigger = 1'b0;
    endtask

    task automatic wait_passes(input int n, input int lim);
        int got;
        got = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clock);
            #2;
            if ((pd_cnt >= n) && !busy) begin
                got = 1;
                break;
            end
        end
        check("pass_wait", got, 1);
    endtask

    // Behavioural sources plus output monitor; runs on the falling edge.
    initial begin
        src_start_ack = '0;
        src_done      = '0;
        src_valid     = '0;
        src_dout      = '0;
        fb_ready      = 1'b0;
        for (int s = 0; s < 2; s++) begin
            st[s]   = 0;
            widx[s] = 0;
            xfer[s] = 1'b0;
        end
        forever begin
            @(negedge clock);
            for (int s = 0; s < 2; s++) begin
                if (!reset_n) begin
                    st[s]            = 0;
                    widx[s]          = 0;
                    src_start_ack[s] = 1'b0;
                    src_valid[s]     = 1'b0;
                    src_done[s]      = 1'b0;
                end else begin
                    case (st[s])
                        0: if (src_start[s] && !noack[s]) begin
                            src_start_ack[s] = 1'b1;
                            st[s]            = 1;
                        end
                        1: begin
                            src_start_ack[s]     = 1'b0;
                            widx[s]              = 0;
                            src_valid[s]         = 1'b1;
                            src_dout[s*54 +: 54] = mk(s, 0);
                            st[s]                = 2;
                        end
                        2: begin
                            if (xfer[s]) widx[s]++;
                            if (widx[s] >= nwords[s]) begin
                                src_valid[s] = 1'b0;
                                src_done[s]  = 1'b1;
                                st[s]        = 3;
                            end else begin
                                src_dout[s*54 +: 54] = mk(s, widx[s]);
                            end
                        end
                        3: if (src_done_ack[s]) begin
                            src_done[s] = 1'b0;
                            st[s]       = 0;
                        end
                        default: st[s] = 0;
                    endcase
                end
            end
            fb_ready = tog ? ~fb_ready : rdy_cfg;
            #1;
            for (int s = 0; s < 2; s++) xfer[s] = src_valid[s] && src_ready[s];
            if (src_start[0]) start0_seen = 1;
            if (pass_done) pd_cnt++;
            if (overrun) ov_cnt++;
            if (fb_valid) check("rdy_mirror", src_ready, src_valid & {2{fb_ready}});
            if (fb_valid && fb_ready) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL extra_word observed=%0h expected=none", fb_dout);
                end else begin
                    check("fb_word", fb_dout, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n  = 1'b0;
        trigger  = 1'b0;
        src_en   = 2'b00;
        rdy_cfg  = 1'b0;
        tog      = 1'b0;
        nwords   = '{64, 64};
        noack    = '{0, 0};
        clear_counts();
        repeat (3) @(negedge clock);
        #1;
        check("rst_start",    src_start,    0);
        check("rst_done_ack", src_done_ack, 0);
        check("rst_ready",    src_ready,    0);
        check("rst_fb_valid", fb_valid,     0);
        check("rst_fb_dout",  fb_dout,      0);
        check("rst_busy",     busy,         0);
        check("rst_pass",     pass_done,    0);
        check("rst_overrun",  overrun,      0);
        check("rst_skip",     skip_err,     0);
        @(negedge clock);
        reset_n = 1'b1;

        // Two full sources, frame bit starts at 1
        rdy_cfg = 1'b1;
        src_en  = 2'b11;
        push_pass(2'b11, 1'b1);
        clear_counts();
        do_trigger();
        check("t1_start_lat", src_start, 2'b01);
        check("t1_busy",      busy,      1);
        wait_passes(1, 2000);
        check("t1_words", words_seen,   128);
        check("t1_pass",  pd_cnt,       1);
        check("t1_queue", exp_q.size(), 0);
        check("t1_skip",  skip_err,     0);

        // Only source 1 enabled, frame now 0
        src_en    = 2'b10;
        nwords[1] = 5;
        push_pass(2'b10, 1'b0);
        clear_counts();
        do_trigger();
        check("t2_start_lat", src_start, 2'b10);
        wait_passes(1, 500);
        check("t2_src0_start", start0_seen,  0);
        check("t2_words",      words_seen,   5);
        check("t2_pass",       pd_cnt,       1);
        check("t2_queue",      exp_q.size(), 0);

        // Backpressure: fb_ready alternates every cycle
        src_en = 2'b11;
        nwords = '{8, 8};
        push_pass(2'b11, 1'b1);
        clear_counts();
        tog = 1'b1;
        do_trigger();
        wait_passes(1, 500);
        tog = 1'b0;
        check("t3_words", words_seen,   16);
        check("t3_pass",  pd_cnt,       1);
        check("t3_queue", exp_q.size(), 0);

        // Three extra triggers mid-pass: one pending, two overruns
        nwords = '{20, 20};
        push_pass(2'b11, 1'b0);
        push_pass(2'b11, 1'b1);
        clear_counts();
        do_trigger();
        repeat (4) @(negedge clock);
        for (int t = 0; t < 3; t++) begin
            do_trigger();
            @(negedge clock);
        end
        wait_passes(2, 1000);
        check("t4_overrun", ov_cnt,       2);
        check("t4_pass",    pd_cnt,       2);
        check("t4_words",   words_seen,   80);
        check("t4_queue",   exp_q.size(), 0);

        // Reset in the middle of streaming
        nwords = '{64, 64};
        push_pass(2'b11, 1'b0);
        clear_counts();
        do_trigger();
        begin
            int got;
            got = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clock);
                #1;
                if (fb_valid) begin
                    got = 1;
                    break;
                end
            end
            check("t5_stream_wait", got, 1);
        end
        repeat (5) @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("t5_start",    src_start,    0);
        check("t5_done_ack", src_done_ack, 0);
        check("t5_ready",    src_ready,    0);
        check("t5_fb_valid", fb_valid,     0);
        check("t5_fb_dout",  fb_dout,      0);
        check("t5_busy",     busy,         0);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        nwords  = '{4, 4};
        push_pass(2'b11, 1'b1);
        clear_counts();
        do_trigger();
        check("t5_restart_src0", src_start, 2'b01);
        wait_passes(1, 500);
        check("t5_words", words_seen,   8);
        check("t5_queue", exp_q.size(), 0);

`ifdef OVERLAY_SCHED_WDOG_EN
        // Source 0 never acknowledges start
        noack[0]  = 1;
        nwords[1] = 4;
        push_pass(2'b10, 1'b0);
        clear_counts();
        do_trigger();
        repeat (15) @(negedge clock);
        check("t6_start_held", src_start[0], 1);
        check("t6_skip_pre",   skip_err,     0);
        @(negedge clock);
        #1;
        check("t6_skip",       skip_err,     2'b01);
        wait_passes(1, 500);
        check("t6_words",      words_seen,   4);
        check("t6_queue",      exp_q.size(), 0);
        noack[0] = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/overlay_sched.md
# overlay_sched

Sequencing controller and write-port arbiter for the overlay generators that feed the frame buffer. On each frame trigger it walks the enabled sources in index order. For each source it runs the start/start_ack handshake, streams that source's 54-bit writes (mask, frame, addr, pixel) to the single frame-buffer write port, then runs the done/done_ack handshake. It also owns the frame-select bit stamped on every outgoing write.

## Interface
- `NUM_SRC`, 2: number of overlay sources (1–8).
- `WDOG_CYC`, 1024: start_ack watchdog limit in cycles (used only with the watchdog macro).
- `clock` in 1: system clock, all logic on the rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `trigger` in 1: single-cycle pulse requesting one pass.
- `src_en` in NUM_SRC: per-source enable, sampled at pass start.
- `src_start` out NUM_SRC: start request to source k.
- `src_start_ack` in NUM_SRC: start acknowledge from source k.
- `src_done` in NUM_SRC: source k finished streaming.
- `src_done_ack` out NUM_SRC: done acknowledge to source k.
- `src_dout` in 54*NUM_SRC: source k word in bits [54k+53:54k].
- `src_valid` in NUM_SRC: source word valid.
- `src_ready` out NUM_SRC: source word accepted.
- `fb_dout` out 54: word to the frame buffer.
- `fb_valid` out 1: fb_dout valid.
- `fb_ready` in 1: frame buffer accepts.
- `busy` out 1: pass in progress.
- `pass_done` out 1: one-cycle pulse at the end of a pass.
- `overrun` out 1: one-cycle pulse when a trigger is dropped.
- `skip_err` out NUM_SRC: sticky per-source watchdog skip flags; cleared at each pass start.

## Operation
- FSM states: IDLE, START, STREAM, DACK, NEXT.
- IDLE:
  - On a trigger or a pending trigger: latch `src_en` into `en_q`, clear `skip_err`, set k to the lowest enabled index, enter START.
  - If no source is enabled, go straight to the end-of-pass actions: toggle the frame bit, pulse pass_done.
- START: drive `src_start[k]`=1 and hold it until `src_start_ack[k]`=1. Then drop it and enter STREAM.
- STREAM:
  - Connections: `fb_dout` = `src_dout[k]` with bit 49 replaced by the frame register; `fb_valid` = `src_valid[k]`; `src_ready[k]` = `fb_ready`.
  - All other src_ready outputs stay 0.
  - On `src_done[k]`=1, enter DACK; from that cycle on, `fb_valid`=0.
- DACK: drive `src_done_ack[k]`=1 until `src_done[k]`=0. Then drop it and enter NEXT.
- NEXT:
  - If another enabled index above k exists, set k to it and enter START.
  - Otherwise toggle the frame register, pulse pass_done, and enter IDLE.
- Trigger handling:
  - A trigger while busy sets `pending`, a 1-deep flag.
  - A trigger while `pending` is already set is dropped and pulses overrun.
  - A trigger in the same cycle as pass_done becomes pending.
- Word fields: mask [53:50], frame [49], addr [48:32], pixel [31:0]. Fields other than frame pass through unmodified.

## Timing
- Reset values: all outputs 0, frame register 1, `pending` 0, state IDLE, k 0.
- Trigger to `src_start` high: 1 cycle (registered).
- The stream path is combinational: zero-latency valid/ready pass-through, with no buffering.
- A word transfers only when `fb_valid` and `fb_ready` are both high.
- Source switch: at least 3 cycles between the last word of source k and the first `src_start` of the next source.
- Reset mid-pass:
  - All handshake outputs deassert immediately.
  - Sources are not acked.
  - The frame register returns to 1.

## Configuration
- `OVERLAY_SCHED_WDOG_EN` defined:
  - In START, a counter increments each cycle.
  - When it reaches `WDOG_CYC` with no ack, `src_start[k]` drops, `skip_err[k]` sets, and the FSM goes to NEXT.
- Not defined: the FSM waits in START indefinitely, and `skip_err` is tied to 0.

## Structure
- Package `overlay_pkg`:
  - Word width 54.
  - Field offsets and widths (MASK, FRAME, ADDR, PIXEL).
  - FSM state enum.
- Sub-module `overlay_word_mux`: combinational NUM_SRC:1 selection of dout/valid, demux of ready, and frame-bit substitution.

## Test plan
- Both sources enabled; each streams 64 words with `fb_ready`=1; trigger once:
  - All 128 words appear in order, source 0 then source 1.
  - Bit 49 = 1 on every word.
  - pass_done pulses once.
  - The frame register becomes 0.
- `src_en`=2'b10: source 0 never sees `src_start`; only source 1's words appear.
- `fb_ready` toggles 1/0 every cycle during STREAM: no words are lost or duplicated; `src_ready[k]` mirrors `fb_ready`.
- Three triggers during a busy pass:
  - One pending pass runs after pass_done.
  - overrun pulses twice.
- With the watchdog macro and `WDOG_CYC`=16, source 0 never acks:
  - `skip_err`=2'b01 after 16 cycles.
  - Source 1 then streams normally.
- Assert `reset_n` low in mid-STREAM: all outputs are 0 in that cycle and frame=1; a new trigger after release restarts from source 0.
